// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle sequencing controller and the datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic [2:0] func3;
  logic       func7;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_Write;
  logic       Adr_Src;
  logic       Mem_Write;
  logic       IR_Write;
  logic       Reg_Write;
  logic [1:0] Result_Src;
  logic [1:0] ALU_Src_A;
  logic [1:0] ALU_Src_B;
  logic [1:0] Imm_Src;
  logic [2:0] ALU_Control;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, func3, func7, Zero, Mem_Ready,
    output PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write, Result_Src,
           ALU_Src_A, ALU_Src_B, Imm_Src, ALU_Control, Illegal, State
  );

  modport slave (
    output Opcode, func3, func7, Zero, Mem_Ready,
    input  PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write, Result_Src,
           ALU_Src_A, ALU_Src_B, Imm_Src, ALU_Control, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RISC-V core (one ALU, one memory port).
// Define MC_JAL_EN to decode jal; otherwise opcode 1101111 traps as illegal.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state;
  state_t     next_state;
  state_t     view;
  logic       illegal_q;
  logic [2:0] alu_func;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE && next_state == TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (bus.Mem_Ready) next_state = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
`ifdef MC_JAL_EN
          OP_JAL:       next_state = JAL;
`endif
          default:      next_state = TRAP;
        endcase
      end
      // Opcode bit 5 separates sw from lw.
      MEMADR:   next_state = bus.Opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.Mem_Ready) next_state = MEMWB;
      MEMWRITE: if (bus.Mem_Ready) next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      MEMWB:    next_state = FETCH;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  // Only R-type (Opcode[5]=1) may turn func3 000 into a subtract.
  always_comb begin
    alu_func = 3'b000;
    case (bus.func3)
      3'b000:  alu_func = (bus.Opcode[5] & bus.func7) ? 3'b001 : 3'b000;
      3'b010:  alu_func = 3'b101;
      3'b110:  alu_func = 3'b011;
      3'b111:  alu_func = 3'b010;
      default: alu_func = 3'b000;
    endcase
  end

  always_comb begin
    bus.Imm_Src = 2'b00;
    case (bus.Opcode)
      OP_SW:   bus.Imm_Src = 2'b01;
      OP_BEQ:  bus.Imm_Src = 2'b10;
`ifdef MC_JAL_EN
      OP_JAL:  bus.Imm_Src = 2'b11;
`endif
      default: bus.Imm_Src = 2'b00;
    endcase
  end

  // While reset is high the selects look like FETCH but every write enable is held off.
  always_comb begin
    view            = rst ? FETCH : state;
    bus.PC_Write    = 1'b0;
    bus.Adr_Src     = 1'b0;
    bus.Mem_Write   = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Reg_Write   = 1'b0;
    bus.Result_Src  = 2'b00;
    bus.ALU_Src_A   = 2'b00;
    bus.ALU_Src_B   = 2'b00;
    bus.ALU_Control = 3'b000;
    case (view)
      FETCH: begin
        bus.IR_Write   = bus.Mem_Ready;
        bus.PC_Write   = bus.Mem_Ready;
        bus.ALU_Src_B  = 2'b10;
        bus.Result_Src = 2'b10;
      end
      DECODE: begin
        bus.ALU_Src_A = 2'b01;
        bus.ALU_Src_B = 2'b01;
      end
      MEMADR: begin
        bus.ALU_Src_A = 2'b10;
        bus.ALU_Src_B = 2'b01;
      end
      MEMREAD:  bus.Adr_Src = 1'b1;
      MEMWB: begin
        bus.Result_Src = 2'b01;
        bus.Reg_Write  = 1'b1;
      end
      MEMWRITE: begin
        bus.Adr_Src   = 1'b1;
        bus.Mem_Write = 1'b1;
      end
      EXECUTER: begin
        bus.ALU_Src_A   = 2'b10;
        bus.ALU_Control = alu_func;
      end
      EXECUTEI: begin
        bus.ALU_Src_A   = 2'b10;
        bus.ALU_Src_B   = 2'b01;
        bus.ALU_Control = alu_func;
      end
      ALUWB:    bus.Reg_Write = 1'b1;
      BEQ: begin
        bus.ALU_Src_A   = 2'b10;
        bus.ALU_Control = 3'b001;
        bus.PC_Write    = bus.Zero;
      end
      JAL: begin
        bus.ALU_Src_A = 2'b01;
        bus.ALU_Src_B = 2'b10;
        bus.PC_Write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.PC_Write = 1'b0;
      bus.IR_Write = 1'b0;
    end
  end

  assign bus.Illegal = illegal_q;
  assign bus.State   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller; corner cases (trap, jal,
// reset mid-instruction) are hand-written sequences after the table.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef struct {
    logic        rst_v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vecs[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing order: State, PC_Write, Adr_Src, Mem_Write, IR_Write, Reg_Write,
  // Result_Src, ALU_Src_A, ALU_Src_B, ALU_Control, Imm_Src, Illegal.
  function automatic logic [20:0] ex(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic ill);
    return {st, pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  function automatic logic [20:0] got_outputs();
    return {bus.State, bus.PC_Write, bus.Adr_Src, bus.Mem_Write, bus.IR_Write,
            bus.Reg_Write, bus.Result_Src, bus.ALU_Src_A, bus.ALU_Src_B,
            bus.ALU_Control, bus.Imm_Src, bus.Illegal};
  endfunction

  task automatic addRow(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy,
                        input logic [20:0] e);
    vec_t v;
    v.rst_v = r; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z, input logic rdy);
    rst           = r;
    bus.Opcode    = op;
    bus.func3     = f3;
    bus.func7     = f7;
    bus.Zero      = z;
    bus.Mem_Ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = got_outputs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic checkField(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset, held two cycles.
    addRow(1, OP_LW, 3'b010, 0, 0, 1, ex(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(1, OP_LW, 3'b010, 0, 0, 1, ex(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    // lw with two stall cycles in MEMREAD: 0,1,2,3,3,3,4.
    addRow(0, OP_LW, 3'b010, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 1, ex(2,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 0, ex(3,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 0, ex(3,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 1, ex(3,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_LW, 3'b010, 0, 0, 1, ex(4,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0));
    // sw with one stall cycle in MEMWRITE.
    addRow(0, OP_SW, 3'b010, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b01,0));
    addRow(0, OP_SW, 3'b010, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0));
    addRow(0, OP_SW, 3'b010, 0, 0, 1, ex(2,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0));
    addRow(0, OP_SW, 3'b010, 0, 0, 0, ex(5,0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));
    addRow(0, OP_SW, 3'b010, 0, 0, 1, ex(5,0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0));
    // R-type sub.
    addRow(0, OP_R, 3'b000, 1, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b000, 1, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b000, 1, 0, 1, ex(6,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0));
    addRow(0, OP_R, 3'b000, 1, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    // R-type add, slt, and: EXECUTE state only differs in ALU_Control.
    addRow(0, OP_R, 3'b000, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b000, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b000, 0, 0, 1, ex(6,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b000, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b010, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b010, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b010, 0, 0, 1, ex(6,0,0,0,0,0,2'b00,2'b10,2'b00,3'b101,2'b00,0));
    addRow(0, OP_R, 3'b010, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b111, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b111, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b111, 0, 0, 1, ex(6,0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0));
    addRow(0, OP_R, 3'b111, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    // I-type with func7=1, func3=000 stays add; then ori; then func3=001 falls back to add.
    addRow(0, OP_I, 3'b000, 1, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b000, 1, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b000, 1, 0, 1, ex(8,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b000, 1, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b110, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b110, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b110, 0, 0, 1, ex(8,0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00,0));
    addRow(0, OP_I, 3'b110, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b001, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b001, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b001, 0, 0, 1, ex(8,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0));
    addRow(0, OP_I, 3'b001, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));
    // beq taken then not taken.
    addRow(0, OP_BEQ, 3'b000, 0, 1, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0));
    addRow(0, OP_BEQ, 3'b000, 0, 1, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    addRow(0, OP_BEQ, 3'b000, 0, 1, 1, ex(10,1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0));
    addRow(0, OP_BEQ, 3'b000, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0));
    addRow(0, OP_BEQ, 3'b000, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0));
    addRow(0, OP_BEQ, 3'b000, 0, 0, 1, ex(10,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0));
    // FETCH stall: no PC/IR write until memory is ready; then R-type or.
    addRow(0, OP_R, 3'b110, 0, 0, 0, ex(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b110, 0, 0, 1, ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b110, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    addRow(0, OP_R, 3'b110, 0, 0, 1, ex(6,0,0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0));
    addRow(0, OP_R, 3'b110, 0, 0, 1, ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0));

    applyStimulus(1, OP_LW, 3'b010, 0, 0, 1);
    step();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_v, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end

    // Illegal opcode: trap holds with no enables until reset.
    applyStimulus(0, OP_SYS, 3'b000, 0, 0, 1);
    checkOutput("sys_fetch", ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step();
    checkOutput("sys_decode", ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    step();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("trap%0d", i), ex(11,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));
      step();
    end
    applyStimulus(1, OP_SYS, 3'b000, 0, 0, 1);
    step();
    checkOutput("trap_reset", ex(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));

    // jal: decoded only when MC_JAL_EN is defined.
    applyStimulus(0, OP_JAL, 3'b000, 0, 0, 1);
`ifdef MC_JAL_EN
    checkOutput("jal_fetch", ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b11,0));
    step();
    checkOutput("jal_decode", ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0));
    step();
    checkOutput("jal_exec", ex(9,1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0));
    step();
    checkOutput("jal_wb", ex(7,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b11,0));
    step();
    checkField("jal_done_state", int'(bus.State), 0);
`else
    checkOutput("jal_fetch", ex(0,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0));
    step();
    checkOutput("jal_decode", ex(1,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0));
    step();
    checkOutput("jal_trap", ex(11,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1));
    applyStimulus(1, OP_JAL, 3'b000, 0, 0, 1);
    step();
    checkField("jal_trap_clear", int'(bus.Illegal), 0);
`endif

    // Reset arriving in MEMWB abandons the load without a register write.
    applyStimulus(0, OP_LW, 3'b010, 0, 0, 1);
    for (int i = 0; i < 4; i++) step();
    checkField("mid_state_mwb", int'(bus.State), 4);
    applyStimulus(1, OP_LW, 3'b010, 0, 0, 1);
    checkField("mid_reg_write", int'(bus.Reg_Write), 0);
    checkField("mid_result_src", int'(bus.Result_Src), 2);
    checkField("mid_pc_ir", int'({bus.PC_Write, bus.IR_Write, bus.Mem_Write}), 0);
    step();
    checkField("mid_state_after", int'(bus.State), 0);
    applyStimulus(0, OP_LW, 3'b010, 0, 0, 1);
    checkField("mid_fetch_pcw", int'(bus.PC_Write), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
